tcam_wordline_driver: RTL and testbench
=======================================

# tcam_wordline_driver

Sequenced word-line decoder for the 16-entry TCAM write path. It accepts a 4-bit entry index over a valid/ready handshake and decodes it to a one-hot 16-bit word-line select. The select is held for a programmable pulse width, followed by a mandatory all-low gap cycle. An optional sweep mode drives every line 0..15 in turn, used for bulk clear/init. It sits between the TCAM write controller and the cell-array write enables, and is the inverse of the match-line priority encoder.

## Interface
- PULSE_CYCLES, 2, cycles each word line stays asserted; legal range 1..16
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_index  input  4  target entry (0..15)
- req_all  input  1  sweep request: drive all 16 lines; req_index is ignored
- wl  output  16  one-hot word-line select; all zero when idle or in gap
- wl_index  output  4  binary index of the line currently driven (0 when wl==0)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the whole operation finishes

## Operation
- States: IDLE, DRIVE, GAP.
- IDLE
  - req_ready=1, wl=0, busy=0.
  - On req_valid&&req_ready, capture the index (or 0 if req_all=1 and sweep is compiled in), capture the sweep flag, load the pulse counter with PULSE_CYCLES-1, and go to DRIVE.
- DRIVE
  - wl = 1<<cur_index, wl_index = cur_index.
  - Counter decrements each cycle; at 0, go to GAP.
- GAP
  - wl=0, wl_index=0. Gives break-before-make between consecutive lines.
  - Single op, or sweep with cur_index==15: assert done and go to IDLE.
  - Otherwise (sweep): cur_index+1, reload counter, go to DRIVE.
- req_ready is 0 outside IDLE. req_valid held during busy is ignored and is not queued. Requests are accepted only in IDLE.
- Index arithmetic is 4-bit. The sweep terminates at 15 and never wraps to 0.
- wl must never have more than one bit set. It is never nonzero in consecutive DRIVE cycles of different indices.
- Reset mid-operation: on the next edge, go to IDLE, wl=0, done=0, and clear the counter and index. No done pulse is issued for the aborted op.

## Timing
- Reset values: req_ready=1, wl=16'h0000, wl_index=0, busy=0, done=0. All outputs are registered.
- Single op accepted at edge T:
  - wl valid at cycles T+1..T+PULSE_CYCLES.
  - GAP with done=1 at T+PULSE_CYCLES+1.
  - req_ready=1 at T+PULSE_CYCLES+2.
- Sweep accepted at T:
  - Line k is driven at cycles T+1+k(P+1) .. T+k(P+1)+P.
  - done is in the final GAP at T+16(P+1).
- Back-to-back throughput: one single op per PULSE_CYCLES+2 cycles.

## Configuration
- TCAM_WL_SWEEP_EN defined: req_all is honoured as described.
- Undefined: req_all is ignored and every request is a single-index op. The sweep flag and the terminal-index logic are removed. done always fires after the first GAP.

## Test plan
- PULSE_CYCLES=2, reset then idle 5 cycles -> wl=0, req_ready=1, busy=0, done=0 throughout.
- Request index 9 at T -> wl=16'h0200 and wl_index=9 at T+1 and T+2; wl=0 and done=1 at T+3; req_ready=1 at T+4.
- Request index 3, with req_valid held high carrying index 5 during busy -> only 16'h0008 is driven. Index 5 is accepted at the first IDLE cycle, and wl=16'h0020 appears two cycles after the first done.
- Sweep (TCAM_WL_SWEEP_EN) at T -> lines 0..15 driven in order, each for 2 cycles with a 1-cycle gap. wl is always one-hot or zero. A single done pulse occurs at T+48.
- Assert rst during DRIVE of line 6 in a sweep -> next edge wl=0, busy=0, no done pulse. A new request for index 1 then completes normally.
- PULSE_CYCLES=1, index 15 and index 0 back-to-back -> 16'h8000 for 1 cycle, gap, then idle, then 16'h0001 for 1 cycle. There is no cycle with two bits set.

Source files
------------

// File: rtl/tcam_wordline_driver.sv
// rtl/tcam_wordline_driver.sv - sequenced one-hot word-line driver for the 16-entry TCAM write path
// Optional sweep mode (drive lines 0..15 in turn) is compiled in with TCAM_WL_SWEEP_EN.
module tcam_wordline_driver #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_index,
  input  logic        req_all,
  output logic [15:0] wl,
  output logic [3:0]  wl_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LOAD = 5'(PULSE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [15:0] wl_q, wl_d;
  logic [3:0]  wl_index_q, wl_index_d;
  logic        last;

`ifdef TCAM_WL_SWEEP_EN
  logic sweep_q, sweep_d;

  // A sweep ends only after line 15; the index never wraps back to 0.
  assign last = !sweep_q || (idx_q == 4'd15);
`else
  logic unused_req_all;

  assign unused_req_all = req_all;
  assign last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef TCAM_WL_SWEEP_EN
    sweep_d = sweep_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
`ifdef TCAM_WL_SWEEP_EN
          sweep_d = req_all;
          idx_d   = req_all ? 4'd0 : req_index;
`else
          idx_d   = req_index;
`endif
          cnt_d   = CNT_LOAD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 5'd0) begin
          state_d = S_GAP;
          done_d  = last;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = CNT_LOAD;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    wl_d       = (state_d == S_DRIVE) ? (16'h0001 << idx_d) : 16'h0000;
    wl_index_d = (state_d == S_DRIVE) ? idx_d : 4'd0;
    busy_d     = (state_d != S_IDLE);
    ready_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      cnt_q      <= 5'd0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      wl_q       <= 16'h0000;
      wl_index_q <= 4'd0;
`ifdef TCAM_WL_SWEEP_EN
      sweep_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      wl_q       <= wl_d;
      wl_index_q <= wl_index_d;
`ifdef TCAM_WL_SWEEP_EN
      sweep_q    <= sweep_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wl        = wl_q;
  assign wl_index  = wl_index_q;

endmodule

// File: tb/tb_tcam_wordline_driver.sv
// tb/tb_tcam_wordline_driver.sv - directed checks of tcam_wordline_driver at PULSE_CYCLES=2 and 1
// Sweep steps are exercised when TCAM_WL_SWEEP_EN is defined; otherwise req_all must be ignored.
module tb_tcam_wordline_driver;

  logic clk = 1'b0;
  logic rst;

  logic        a_valid, a_ready, a_all, a_busy, a_done;
  logic [3:0]  a_index, a_wl_index;
  logic [15:0] a_wl;

  logic        b_valid, b_ready, b_all, b_busy, b_done;
  logic [3:0]  b_index, b_wl_index;
  logic [15:0] b_wl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tcam_wordline_driver #(.PULSE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_index(a_index), .req_all(a_all),
    .wl(a_wl), .wl_index(a_wl_index), .busy(a_busy), .done(a_done)
  );

  tcam_wordline_driver #(.PULSE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_index(b_index), .req_all(b_all),
    .wl(b_wl), .wl_index(b_wl_index), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [15:0] wl_e, input logic [3:0] idx_e,
                       input logic rdy_e, input logic busy_e, input logic done_e);
    chk({tag, " wl"}, 32'(a_wl), 32'(wl_e));
    chk({tag, " wl_index"}, 32'(a_wl_index), 32'(idx_e));
    chk({tag, " req_ready"}, 32'(a_ready), 32'(rdy_e));
    chk({tag, " busy"}, 32'(a_busy), 32'(busy_e));
    chk({tag, " done"}, 32'(a_done), 32'(done_e));
  endtask

  task automatic chk_b(input string tag, input logic [15:0] wl_e, input logic [3:0] idx_e,
                       input logic rdy_e, input logic done_e);
    chk({tag, " wl"}, 32'(b_wl), 32'(wl_e));
    chk({tag, " wl_index"}, 32'(b_wl_index), 32'(idx_e));
    chk({tag, " req_ready"}, 32'(b_ready), 32'(rdy_e));
    chk({tag, " done"}, 32'(b_done), 32'(done_e));
    chk({tag, " onehot0"}, 32'($onehot0(b_wl)), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_index = 4'd0; a_all = 1'b0;
    b_valid = 1'b0; b_index = 4'd0; b_all = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_a("idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      chk_b("idle_b", 16'h0000, 4'd0, 1'b1, 1'b0);
    end

    // Single op, index 9.
    a_valid = 1'b1; a_index = 4'd9;
    @(negedge clk); a_valid = 1'b0;
    chk_a("idx9 T+1", 16'h0200, 4'd9, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx9 T+2", 16'h0200, 4'd9, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx9 gap", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_a("idx9 idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // Index 3 with req_valid held carrying index 5 while busy.
    a_valid = 1'b1; a_index = 4'd3;
    @(negedge clk); a_index = 4'd5;
    chk_a("hold T+1", 16'h0008, 4'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("hold T+2", 16'h0008, 4'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("hold gap", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_a("hold idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); a_valid = 1'b0;
    chk_a("idx5 T+1", 16'h0020, 4'd5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx5 T+2", 16'h0020, 4'd5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx5 gap", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_a("idx5 idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

`ifdef TCAM_WL_SWEEP_EN
    // Full sweep: line k during cycles 3k+1..3k+2, gap at 3k+3, done only at 48.
    a_valid = 1'b1; a_all = 1'b1; a_index = 4'd7;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 1) begin a_valid = 1'b0; a_all = 1'b0; end
      if ((c - 1) % 3 < 2)
        chk_a($sformatf("sweep c%0d", c), 16'h0001 << ((c - 1) / 3), 4'((c - 1) / 3), 1'b0, 1'b1, 1'b0);
      else
        chk_a($sformatf("sweep c%0d", c), 16'h0000, 4'd0, 1'b0, 1'b1, 1'(c == 48));
    end
    @(negedge clk);
    chk_a("sweep end", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reset while line 6 of a sweep is driven.
    a_valid = 1'b1; a_all = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin a_valid = 1'b0; a_all = 1'b0; end
    end
    chk_a("pre-rst line6", 16'h0040, 4'd6, 1'b0, 1'b1, 1'b0);
`else
    // req_all is ignored: a plain single op on req_index.
    a_valid = 1'b1; a_all = 1'b1; a_index = 4'd7;
    @(negedge clk); a_valid = 1'b0; a_all = 1'b0;
    chk_a("noswp T+1", 16'h0080, 4'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("noswp T+2", 16'h0080, 4'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("noswp gap", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_a("noswp idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reset while index 6 is driven.
    a_valid = 1'b1; a_index = 4'd6;
    @(negedge clk); a_valid = 1'b0;
    chk_a("pre-rst idx6", 16'h0040, 4'd6, 1'b0, 1'b1, 1'b0);
`endif
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_a("rst abort", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_a("post-rst idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    a_valid = 1'b1; a_index = 4'd1;
    @(negedge clk); a_valid = 1'b0;
    chk_a("idx1 T+1", 16'h0002, 4'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx1 T+2", 16'h0002, 4'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_a("idx1 gap", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_a("idx1 idle", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // PULSE_CYCLES=1: index 15 then index 0 back-to-back.
    b_valid = 1'b1; b_index = 4'd15;
    @(negedge clk); b_index = 4'd0;
    chk_b("p1 idx15", 16'h8000, 4'd15, 1'b0, 1'b0);
    @(negedge clk);
    chk_b("p1 gap15", 16'h0000, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_b("p1 idle", 16'h0000, 4'd0, 1'b1, 1'b0);
    @(negedge clk); b_valid = 1'b0;
    chk_b("p1 idx0", 16'h0001, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_b("p1 gap0", 16'h0000, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_b("p1 end", 16'h0000, 4'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
